// File: rtl/whitening_pkg.sv
// whitening_pkg: shared FSM states and sizing constants for the whitening-stage controllers
package whitening_pkg;
  localparam int COV_N_SAMPLES = 128;
  localparam int COV_SHIFT = $clog2(COV_N_SAMPLES);
  localparam int SAMPLE_ADDR_W = 7;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_ISSUE, ST_DRAIN, ST_DONE} cov_state_e;
endpackage

// File: rtl/valid_align_pipe.sv
// valid_align_pipe: stall-gated valid shift register.
// Ports: clk, rst (sync, active-high), stall_i freezes the pipe,
// vld_i enters stage 0, vld_o is the last stage (suppressed while stalled).
module valid_align_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic vld_i,
  output logic vld_o
);
  logic [DEPTH-1:0] pipe_q, pipe_d;
  always_comb pipe_d = stall_i ? pipe_q : DEPTH'({pipe_q, vld_i});
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else pipe_q <= pipe_d;
  end
  assign vld_o = pipe_q[DEPTH-1] & ~stall_i;
endmodule

// File: rtl/cov_accum_ctrl.sv
// cov_accum_ctrl: sequencer for the whitening-stage covariance accumulator.
// Ports: start launches a run; stall freezes issue and alignment;
// mem_rd_en/mem_addr fetch samples; acc_clr/acc_en drive the accumulator;
// busy is high outside IDLE; cov_valid/cov_ack hand the result downstream.
module cov_accum_ctrl
  import whitening_pkg::*;
#(
  parameter int N_SAMPLES = COV_N_SAMPLES,
  parameter int ADDR_W    = SAMPLE_ADDR_W,
  parameter int BASE_ADDR = 0,
  parameter int PIPE_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              busy,
  output logic              cov_valid,
  input  logic              cov_ack
);
  localparam int CW = $clog2(N_SAMPLES) + 1;
  cov_state_e state_q, state_d;
  logic [CW-1:0] issue_q, issue_d, acc_q, acc_d;
  assign mem_rd_en = (state_q == ST_ISSUE) && !stall;
  assign acc_clr   = state_q == ST_CLEAR;
  assign busy      = state_q != ST_IDLE;
  assign cov_valid = state_q == ST_DONE;
  assign mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(issue_q);
  valid_align_pipe #(.DEPTH(PIPE_LAT)) u_align (
    .clk    (clk),
    .rst    (rst),
    .stall_i(stall),
    .vld_i  (mem_rd_en),
    .vld_o  (acc_en)
  );
  always_comb begin
    issue_d = acc_clr ? '0 : issue_q + CW'(mem_rd_en);
    acc_d   = acc_clr ? '0 : acc_q + CW'(acc_en);
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: state_d = ST_ISSUE;
      ST_ISSUE: state_d = (mem_rd_en && issue_q == CW'(N_SAMPLES - 1)) ? ST_DRAIN : ST_ISSUE;
      // look at the next count so cov_valid rises right after the last accumulate
      ST_DRAIN: state_d = (acc_d == CW'(N_SAMPLES)) ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = cov_ack ? ST_IDLE : ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      issue_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_cov_accum_ctrl.sv
// tb_cov_accum_ctrl: randomized self-checking bench for cov_accum_ctrl against a queue-based model
module tb_cov_accum_ctrl;
  localparam int N = 128;
  localparam int LAT = 2;
  localparam int AW = 7;
  localparam int BASE_W = 120;
  logic clk = 1'b0;
  logic rst, start, stall, cov_ack;
  logic rd0, clr0, acc0, busy0, val0, rd1, clr1, acc1, busy1, val1;
  logic [AW-1:0] addr0, addr1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  cov_accum_ctrl dut0 (.clk(clk), .rst(rst), .start(start), .stall(stall), .mem_rd_en(rd0),
    .mem_addr(addr0), .acc_clr(clr0), .acc_en(acc0), .busy(busy0), .cov_valid(val0), .cov_ack(cov_ack));
  cov_accum_ctrl #(.BASE_ADDR(BASE_W)) dut1 (.clk(clk), .rst(rst), .start(start), .stall(stall),
    .mem_rd_en(rd1), .mem_addr(addr1), .acc_clr(clr1), .acc_en(acc1), .busy(busy1), .cov_valid(val1),
    .cov_ack(cov_ack));

  // reference model: run phase, reads issued, products accumulated, and a queue of
  // in-flight reads each holding the number of unstalled cycles until it is accumulated
  localparam int P_IDLE = 0, P_CLEAR = 1, P_ISSUE = 2, P_DRAIN = 3, P_DONE = 4;
  int m_ph = P_IDLE, m_rd = 0, m_acc = 0;
  int q[$];
  bit m_fire;
  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_rd = 0; m_acc = 0; q.delete();
    end else begin
      m_fire = !stall && q.size() > 0 && q[0] == 1;
      if (!stall) foreach (q[i]) q[i]--;
      if (m_fire) begin void'(q.pop_front()); m_acc++; end
      case (m_ph)
        P_IDLE:  if (start) m_ph = P_CLEAR;
        P_CLEAR: begin m_ph = P_ISSUE; m_rd = 0; m_acc = 0; end
        P_ISSUE: if (!stall) begin m_rd++; q.push_back(LAT); if (m_rd == N) m_ph = P_DRAIN; end
        P_DRAIN: if (m_acc == N) m_ph = P_DONE;
        P_DONE:  if (cov_ack) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  task automatic tick(input logic r, input logic st, input logic sl, input logic ak);
    @(posedge clk); #1;
    rst = r; start = st; stall = sl; cov_ack = ak;
    @(negedge clk);
  endtask

  int clr_n, clr_c, rd_n, rd_first, rd_last, acc_n, acc_n1, acc_first, acc_last, v_rise;
  int busy_low, ae0, ae1, stall_act, held_addr;

  // one run from a start at cycle 0, recording what the DUT did (no judging here)
  task automatic run_record(input int ncyc, input int s_lo, input int s_hi, input int rs_c, input int ack_rand);
    logic sl, ak;
    clr_n = 0; clr_c = -1; rd_n = 0; rd_first = -1; rd_last = -1; acc_n = 0; acc_n1 = 0;
    acc_first = -1; acc_last = -1; v_rise = -1; busy_low = 0; ae0 = 0; ae1 = 0; stall_act = 0; held_addr = -1;
    tick(0, 1, 0, 0);
    for (int c = 1; c <= ncyc; c++) begin
      sl = c >= s_lo && c <= s_hi;
      ak = (ack_rand != 0 && c < 132) ? 1'($urandom % 2) : 1'b0;
      tick(0, c == rs_c, sl, ak);
      if (clr0) begin clr_n++; clr_c = c; end
      if (rd0) begin
        if (rd_n == 0) rd_first = c;
        rd_last = c;
        if (addr0 != AW'(rd_n)) ae0++;
        if (addr1 != AW'(BASE_W + rd_n)) ae1++;
        rd_n++;
      end
      if (acc0) begin if (acc_n == 0) acc_first = c; acc_last = c; acc_n++; end
      if (acc1) acc_n1++;
      if (val0 && v_rise < 0) v_rise = c;
      if (!busy0) busy_low++;
      if (sl) begin if (rd0 | acc0) stall_act++; held_addr = int'(addr0); end
    end
  endtask

  task automatic test_reset;
    tick(1, 1, 0, 1);
    checks++; if ({busy0, clr0, rd0, acc0, val0} !== 5'b0) begin errors++; $display("FAIL reset_outs0: got %b want 00000", {busy0, clr0, rd0, acc0, val0}); end
    checks++; if ({busy1, clr1, rd1, acc1, val1} !== 5'b0) begin errors++; $display("FAIL reset_outs1: got %b want 00000", {busy1, clr1, rd1, acc1, val1}); end
    checks++; if (addr0 !== 7'd0) begin errors++; $display("FAIL reset_addr0: got %0d want 0", addr0); end
    checks++; if (addr1 !== 7'd120) begin errors++; $display("FAIL reset_addr1: got %0d want 120", addr1); end
    tick(0, 0, 0, 0);
    checks++; if ({busy0, clr0} !== 2'b0) begin errors++; $display("FAIL reset_no_clr: got %b want 00", {busy0, clr0}); end
  endtask

  task automatic test_nominal;
    tick(1, 0, 0, 0);
    run_record(140, 0, -1, -1, 0);
    checks++; if (clr_n != 1 || clr_c != 1) begin errors++; $display("FAIL nom_clr: got n=%0d c=%0d want n=1 c=1", clr_n, clr_c); end
    checks++; if (rd_first != 2 || rd_last != 129 || rd_n != 128) begin errors++; $display("FAIL nom_rd: got %0d..%0d n=%0d want 2..129 n=128", rd_first, rd_last, rd_n); end
    checks++; if (ae0 != 0) begin errors++; $display("FAIL nom_addr0: got %0d bad want 0", ae0); end
    checks++; if (ae1 != 0) begin errors++; $display("FAIL wrap_addr1: got %0d bad want 0", ae1); end
    checks++; if (acc_first != 4 || acc_last != 131 || acc_n != 128) begin errors++; $display("FAIL nom_acc: got %0d..%0d n=%0d want 4..131 n=128", acc_first, acc_last, acc_n); end
    checks++; if (acc_n1 != 128) begin errors++; $display("FAIL wrap_acc1: got %0d want 128", acc_n1); end
    checks++; if (v_rise != 132) begin errors++; $display("FAIL nom_valid: got %0d want 132", v_rise); end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL nom_busy: got %0d idle cycles want 0", busy_low); end
    tick(0, 0, 0, 1);
    checks++; if (val0 !== 1'b1) begin errors++; $display("FAIL nom_ack_cycle: got %b want 1", val0); end
    tick(0, 0, 0, 0);
    checks++; if ({busy0, val0} !== 2'b0) begin errors++; $display("FAIL nom_after_ack: got %b want 00", {busy0, val0}); end
  endtask

  task automatic test_stall;
    tick(1, 0, 0, 0);
    run_record(145, 12, 16, -1, 0);
    checks++; if (stall_act != 0) begin errors++; $display("FAIL stall_quiet: got %0d active want 0", stall_act); end
    checks++; if (held_addr != 10) begin errors++; $display("FAIL stall_addr: got %0d want 10", held_addr); end
    checks++; if (rd_n != 128 || rd_last != 134 || ae0 != 0) begin errors++; $display("FAIL stall_rd: got n=%0d last=%0d bad=%0d want 128 134 0", rd_n, rd_last, ae0); end
    checks++; if (acc_n != 128 || acc_last != 136) begin errors++; $display("FAIL stall_acc: got n=%0d last=%0d want 128 136", acc_n, acc_last); end
    checks++; if (v_rise != 137) begin errors++; $display("FAIL stall_valid: got %0d want 137", v_rise); end
  endtask

  task automatic test_restart_ignored;
    tick(1, 0, 0, 0);
    run_record(140, 0, -1, 50, 0);
    checks++; if (clr_n != 1 || busy_low != 0) begin errors++; $display("FAIL restart_single: got clr=%0d idle=%0d want 1 0", clr_n, busy_low); end
    checks++; if (acc_n != 128 || rd_n != 128 || v_rise != 132) begin errors++; $display("FAIL restart_counts: got acc=%0d rd=%0d v=%0d want 128 128 132", acc_n, rd_n, v_rise); end
    tick(0, 1, 0, 1);
    tick(0, 1, 0, 0);
    checks++; if ({busy0, clr0} !== 2'b0) begin errors++; $display("FAIL ack_start_drop: got %b want 00", {busy0, clr0}); end
    tick(0, 0, 0, 0);
    checks++; if (clr0 !== 1'b1) begin errors++; $display("FAIL start_after_ack: got %b want 1", clr0); end
  endtask

  task automatic test_ack_hold;
    int hold = 0;
    tick(1, 0, 0, 0);
    run_record(132, 0, -1, -1, 1);
    checks++; if (v_rise != 132) begin errors++; $display("FAIL ack_ignored: got %0d want 132", v_rise); end
    for (int i = 0; i < 20; i++) begin tick(0, 0, 0, 0); if (val0) hold++; end
    checks++; if (hold != 20) begin errors++; $display("FAIL ack_hold: got %0d want 20", hold); end
    tick(0, 0, 0, 1);
    checks++; if (val0 !== 1'b1) begin errors++; $display("FAIL ack_hold_last: got %b want 1", val0); end
    tick(0, 0, 0, 0);
    checks++; if ({busy0, val0} !== 2'b0) begin errors++; $display("FAIL ack_drop: got %b want 00", {busy0, val0}); end
  endtask

  task automatic test_reset_mid;
    tick(1, 0, 0, 0);
    run_record(59, 0, -1, -1, 0);
    checks++; if (rd_n != 58) begin errors++; $display("FAIL mid_pre_reads: got %0d want 58", rd_n); end
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    checks++; if ({busy0, clr0, rd0, acc0, val0} !== 5'b0 || addr0 !== 7'd0) begin errors++; $display("FAIL mid_reset0: got %b addr %0d want 00000 addr 0", {busy0, clr0, rd0, acc0, val0}, addr0); end
    checks++; if ({busy1, clr1, rd1, acc1, val1} !== 5'b0 || addr1 !== 7'd120) begin errors++; $display("FAIL mid_reset1: got %b addr %0d want 00000 addr 120", {busy1, clr1, rd1, acc1, val1}, addr1); end
    run_record(140, 0, -1, -1, 0);
    checks++; if (rd_n != 128 || rd_first != 2 || ae0 != 0) begin errors++; $display("FAIL mid_rerun_rd: got n=%0d first=%0d bad=%0d want 128 2 0", rd_n, rd_first, ae0); end
    checks++; if (acc_n != 128 || v_rise != 132) begin errors++; $display("FAIL mid_rerun_acc: got n=%0d v=%0d want 128 132", acc_n, v_rise); end
  endtask

  task automatic test_random_lockstep;
    logic [4:0] e;
    logic r, sl, prev_val;
    int run_acc = 0;
    tick(1, 0, 0, 0);
    prev_val = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      r = ($urandom % 1500) == 0;
      sl = ((c / 1000) % 2 == 1) ? 1'(c % 2) : 1'(($urandom % 4) == 0);
      tick(r, 1'(($urandom % 8) == 0), sl, 1'(($urandom % 6) == 0));
      e = {m_ph != P_IDLE, m_ph == P_CLEAR, m_ph == P_ISSUE && !stall,
           !stall && q.size() > 0 && q[0] == 1, m_ph == P_DONE};
      checks++; if ({busy0, clr0, rd0, acc0, val0} !== e) begin errors++; $display("FAIL lock_outs0 @%0d: got %b want %b", c, {busy0, clr0, rd0, acc0, val0}, e); end
      checks++; if ({busy1, clr1, rd1, acc1, val1} !== e) begin errors++; $display("FAIL lock_outs1 @%0d: got %b want %b", c, {busy1, clr1, rd1, acc1, val1}, e); end
      if (m_ph == P_ISSUE) begin
        checks++; if (addr0 !== AW'(m_rd) || addr1 !== AW'(BASE_W + m_rd)) begin errors++; $display("FAIL lock_addr @%0d: got %0d/%0d want %0d/%0d", c, addr0, addr1, AW'(m_rd), AW'(BASE_W + m_rd)); end
      end
      if (clr0) run_acc = 0;
      if (acc0) run_acc++;
      if (val0 && !prev_val) begin
        checks++; if (run_acc != N) begin errors++; $display("FAIL lock_run_acc @%0d: got %0d want %0d", c, run_acc, N); end
      end
      prev_val = val0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; cov_ack = 1'b0;
    test_reset;
    test_nominal;
    test_stall;
    test_restart_ignored;
    test_ack_hold;
    test_reset_mid;
    test_random_lockstep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
